// File: rtl/track_req_skid.sv
// Two-entry per-client skid FIFO with a registered ready.
// It holds {mark, label} records in arrival order. The head is visible to the
// arbiter one cycle after the push, so an empty buffer is never bypassed.
module track_req_skid #(
    parameter int DWIDTH = 21
) (
    input  logic              clk,
    input  logic              reset_l,
    input  logic              in_valid,
    input  logic [DWIDTH-1:0] in_data,
    output logic              in_ready,
    input  logic              pop,
    output logic              head_valid,
    output logic [DWIDTH-1:0] head_data
);

    logic [1:0]        count_r;
    logic [DWIDTH-1:0] head_r;
    logic [DWIDTH-1:0] tail_r;
    logic              ready_r;
    logic              push_s;
    logic              pop_s;
    logic [1:0]        count_next_s;

    assign push_s     = in_valid && ready_r;
    assign pop_s      = pop && (count_r != 2'd0);
    assign in_ready   = ready_r;
    assign head_valid = (count_r != 2'd0);
    assign head_data  = head_r;

    // Occupancy after this cycle's push and pop
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + 2'd1;
            2'b01:   count_next_s = count_r - 2'd1;
            default: count_next_s = count_r;
        endcase
    end

    // Storage shift, occupancy and registered ready
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            count_r <= 2'd0;
            ready_r <= 1'b1;
            head_r  <= {DWIDTH{1'b0}};
            tail_r  <= {DWIDTH{1'b0}};
        end else begin
            count_r <= count_next_s;
            ready_r <= (count_next_s < 2'd2);
            case (count_r)
                2'd0: begin
                    if (push_s) head_r <= in_data;
                end
                2'd1: begin
                    if (push_s && pop_s) head_r <= in_data;
                    else if (push_s)     tail_r <= in_data;
                end
                2'd2: begin
                    // ready is low here, so only a pop can happen
                    if (pop_s) head_r <= tail_r;
                end
                default: begin
                    head_r <= head_r;
                end
            endcase
        end
    end

endmodule

// File: rtl/track_req_arb.sv
// Round-robin request arbiter feeding the label-tracking checker's request FIFO.
// Each client has its own skid buffer; a single output register drives the FIFO
// write port and is only written into the FIFO while it is not full.
module track_req_arb #(
    parameter int NCLIENTS   = 4,
    parameter int LABELWIDTH = 20,
    parameter int IDWIDTH    = 3,
    parameter int STALLWIDTH = 16
) (
    input  logic                           clk,
    input  logic                           reset_l,
    input  logic [NCLIENTS-1:0]            req_valid,
    input  logic [NCLIENTS*LABELWIDTH-1:0] req_label,
    input  logic [NCLIENTS-1:0]            req_mark,
    output logic [NCLIENTS-1:0]            req_ready,
    output logic                           out_we,
    output logic [LABELWIDTH-1:0]          out_label,
    output logic                           out_mark,
    input  logic                           out_full,
    output logic [IDWIDTH-1:0]             out_id,
    output logic [STALLWIDTH-1:0]          stall_count
);

    localparam int DW = LABELWIDTH + 1;

    logic [NCLIENTS-1:0]   head_valid_s;
    logic [DW-1:0]         head_data_s [NCLIENTS];
    logic [NCLIENTS-1:0]   pop_s;

    logic                  out_valid_r;
    logic [LABELWIDTH-1:0] out_label_r;
    logic                  out_mark_r;
    logic [IDWIDTH-1:0]    out_id_r;
    logic [IDWIDTH-1:0]    ptr_r;
    logic [STALLWIDTH-1:0] stall_r;

    logic                  out_we_s;
    logic                  can_load_s;
    logic                  hit_hi_s;
    logic                  hit_lo_s;
    logic                  found_hi_s;
    logic                  found_lo_s;
    logic [IDWIDTH-1:0]    idx_hi_s;
    logic [IDWIDTH-1:0]    idx_lo_s;
    logic                  grant_valid_s;
    logic [IDWIDTH-1:0]    grant_idx_s;
    logic [DW-1:0]         grant_data_s;

    for (genvar i = 0; i < NCLIENTS; i++) begin : g_skid
        track_req_skid #(.DWIDTH(DW)) u_skid (
            .clk        (clk),
            .reset_l    (reset_l),
            .in_valid   (req_valid[i]),
            .in_data    ({req_mark[i], req_label[i*LABELWIDTH +: LABELWIDTH]}),
            .in_ready   (req_ready[i]),
            .pop        (pop_s[i]),
            .head_valid (head_valid_s[i]),
            .head_data  (head_data_s[i])
        );
    end

    // The one combinational output path: write whenever staged and not full
    assign out_we_s    = out_valid_r && !out_full;
    assign can_load_s  = !out_valid_r || out_we_s;
    assign out_we      = out_we_s;
    assign out_label   = out_label_r;
    assign out_mark    = out_mark_r;
    assign out_id      = out_id_r;
    assign stall_count = stall_r;

    // Rotating priority: lowest non-empty index above the pointer, else lowest at or below it
    always_comb begin
        hit_hi_s   = 1'b0;
        hit_lo_s   = 1'b0;
        found_hi_s = 1'b0;
        found_lo_s = 1'b0;
        idx_hi_s   = {IDWIDTH{1'b0}};
        idx_lo_s   = {IDWIDTH{1'b0}};
        for (int c = 0; c < NCLIENTS; c++) begin
            hit_hi_s   = head_valid_s[c] && (IDWIDTH'(c) >  ptr_r) && !found_hi_s;
            hit_lo_s   = head_valid_s[c] && (IDWIDTH'(c) <= ptr_r) && !found_lo_s;
            idx_hi_s   = hit_hi_s ? IDWIDTH'(c) : idx_hi_s;
            idx_lo_s   = hit_lo_s ? IDWIDTH'(c) : idx_lo_s;
            found_hi_s = found_hi_s || hit_hi_s;
            found_lo_s = found_lo_s || hit_lo_s;
        end
        grant_valid_s = can_load_s && (found_hi_s || found_lo_s);
        grant_idx_s   = found_hi_s ? idx_hi_s : idx_lo_s;
    end

    // One-hot pop of the granted skid and selection of its head record
    always_comb begin
        pop_s        = {NCLIENTS{1'b0}};
        grant_data_s = {DW{1'b0}};
        for (int c = 0; c < NCLIENTS; c++) begin
            pop_s[c]     = grant_valid_s && (grant_idx_s == IDWIDTH'(c));
            grant_data_s = grant_data_s | ({DW{pop_s[c]}} & head_data_s[c]);
        end
    end

    // Output stage and round-robin pointer
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            out_valid_r <= 1'b0;
            out_label_r <= {LABELWIDTH{1'b0}};
            out_mark_r  <= 1'b0;
            out_id_r    <= {IDWIDTH{1'b0}};
            ptr_r       <= IDWIDTH'(NCLIENTS - 1);
        end else if (grant_valid_s) begin
            out_valid_r <= 1'b1;
            out_label_r <= grant_data_s[LABELWIDTH-1:0];
            out_mark_r  <= grant_data_s[LABELWIDTH];
            out_id_r    <= grant_idx_s;
            ptr_r       <= grant_idx_s;
        end else if (out_we_s) begin
            out_valid_r <= 1'b0;
        end
    end

    // Saturating count of cycles where a staged write is held off by a full FIFO
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            stall_r <= {STALLWIDTH{1'b0}};
        end else if (out_valid_r && out_full && (stall_r != {STALLWIDTH{1'b1}})) begin
            stall_r <= stall_r + STALLWIDTH'(1);
        end
    end

endmodule

// File: doc/track_req_arb.md
Name: track_req_arb

Overview:
- N-way round-robin request arbiter in front of the label-tracking checker's request FIFO (write port: we/label/mark, full back-pressure).
- Replaces the fixed two-client ping-pong scheme. Clients may issue every cycle; each has a 2-entry skid buffer with registered ready.
- Writes are never issued into a full FIFO, so no request is ever dropped.

Parameters:
- NCLIENTS, 4, number of requesters (2..8).
- LABELWIDTH, 20, label width in bits.
- IDWIDTH, 3, width of client index; must satisfy 2**IDWIDTH >= NCLIENTS.
- STALLWIDTH, 16, width of saturating stall counter.

Ports:
- clk  input  1  clock.
- reset_l  input  1  asynchronous active-low reset.
- req_valid  input  NCLIENTS  per-client request valid.
- req_label  input  NCLIENTS*LABELWIDTH  per-client label; client i occupies bits [i*LABELWIDTH +: LABELWIDTH].
- req_mark  input  NCLIENTS  per-client mark (1 = create entry, 0 = remove entry).
- req_ready  output  NCLIENTS  per-client ready, driven from a register.
- out_we  output  1  FIFO write strobe.
- out_label  output  LABELWIDTH  label written to the FIFO.
- out_mark  output  1  mark written to the FIFO.
- out_full  input  1  FIFO full.
- out_id  output  IDWIDTH  client index of the current out_label/out_mark.
- stall_count  output  STALLWIDTH  cycles spent blocked by out_full, saturating.

Behaviour:
- Reset: reset_l is asynchronous and active-low; clock is clk. During reset:
  - all skid buffers are emptied and req_ready = all ones;
  - output stage is invalid, so out_we = 0 and out_label, out_mark, out_id = 0;
  - stall_count = 0;
  - round-robin pointer = NCLIENTS-1, so client 0 has first priority.
- Handshake: a transfer occurs on a rising edge where req_valid[i] && req_ready[i].
  - req_ready[i] is registered: it is 1 while skid i holds fewer than 2 entries after the current cycle's push/pop.
  - A push to a full skid cannot occur. A simultaneous push and pop on a 2-entry skid is legal but unreachable, because ready is already 0.
- Skid buffer: 2-entry FIFO per client holding {mark, label}. Order within a client is preserved.
- Output stage: one register (valid, label, mark, id).
  - out_we = out_valid && !out_full. This is the only combinational output path.
  - The stage pops when out_we = 1.
- Arbitration: each cycle, if the output stage is empty or popping this cycle, grant the first non-empty skid searching from pointer+1 upward, modulo NCLIENTS.
  - The granted head loads into the output stage on the next edge; out_id = granted index.
  - The pointer updates to the granted index. If there is no grant, the pointer holds.
- Latency: from an accepted request on an idle arbiter to out_we = 1 is 2 cycles (skid, then output stage). Sustained throughput is 1 write per cycle.
- Full: while out_full = 1, the output stage holds and there is no grant, so skids fill and drop ready. out_we resumes in the same cycle out_full falls.
- stall_count increments each cycle with out_valid && out_full, saturates at all ones, and clears only on reset.
- Fairness: with all clients continuously pending, the grant sequence is 0,1,...,N-1,0,... Each client waits at most NCLIENTS-1 grants.
- Simultaneous events: pushes into several skids in one cycle are all accepted. A push into an empty skid is not arbitrable until the following cycle, so there is no bypass.
- Reset mid-operation: any buffered or staged requests are discarded, and the outputs return to their reset values immediately (asynchronously).

Decomposition:
- No shared package needed. LABELWIDTH matches the tracking checker's parameter and is passed at instantiation.
- One sub-module: track_req_skid, a 2-entry registered-ready FIFO parameterised by data width LABELWIDTH+1, instanced NCLIENTS times.
- The round-robin search, output stage and stall counter live in the top module.

Test Plan:
- Single request: client 2 sends label 0x00ABC with mark 1 at cycle 10 → out_we high at cycle 12 with out_label = 0x00ABC, out_mark = 1, out_id = 2; req_ready[2] stays 1.
- All 4 clients valid every cycle for 40 cycles, out_full = 0 → out_we continuous from cycle 2; out_id sequence 0,1,2,3 repeating; each client's labels arrive in its own issue order with no loss and no duplication.
- out_full held high for 10 cycles with client 0 streaming → req_ready[0] falls after 2 entries are accepted beyond the staged one; out_we = 0 throughout; stall_count = 10; after release, the 3 held labels emerge in order on consecutive cycles.
- STALLWIDTH = 4 with out_full held 20 cycles while the output stage is valid → stall_count saturates at 15 and does not wrap.
- Clients 1 and 3 only, both always valid → out_id alternates 1,3,1,3; out_id never shows 0 or 2.
- reset_l pulsed low for 1 cycle mid-stream with skids partly full → out_we = 0 immediately, all req_ready = 1, stall_count = 0; the first grant after reset goes to the lowest-index valid client.
